// File: rtl/switch_pkg.sv
// switch_pkg: default parameters and port-index width helper for param_switch
package switch_pkg;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_DEPTH     = 4;
  localparam bit DEF_BCAST_EN  = 1'b1;
  function automatic int port_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/switch_port_fifo.sv
// switch_port_fifo: per-port FIFO; head is zeroed while empty, storage is never reset
module switch_port_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop_req,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] dout,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic pop;
  always_comb begin
    valid   = count_q != '0;
    full    = count_q == CW'(DEPTH);
    pop     = pop_req && valid;
    dout    = valid ? mem_q[rd_q] : '0;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    count_d = (push && !pop) ? count_q + 1'b1 : (!push && pop) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/param_switch.sv
// param_switch: routes input words to per-port FIFOs by index, or to all ports on broadcast
module param_switch
  import switch_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int NUM_PORTS = DEF_NUM_PORTS,
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  bit BCAST_EN  = DEF_BCAST_EN,
  localparam int PORT_W    = port_w(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ready_in,
  input  logic [DATA_W-1:0]           data_in,
  input  logic [PORT_W-1:0]           port_num,
  input  logic                        bcast_in,
  output logic                        in_ack,
  output logic [NUM_PORTS-1:0]        ready_out,
  input  logic [NUM_PORTS-1:0]        out_ack,
  output logic [NUM_PORTS*DATA_W-1:0] data_out,
  output logic [NUM_PORTS-1:0]        fifo_full
);
  localparam logic [PORT_W:0] NP = NUM_PORTS[PORT_W:0];
  logic bcast_eff, in_range, uni_ok, bc_ok;
  always_comb begin
    bcast_eff = BCAST_EN && bcast_in;
    in_range  = {1'b0, port_num} < NP;
    uni_ok    = ready_in && !bcast_eff && in_range && !fifo_full[port_num];
    bc_ok     = ready_in && bcast_eff && !(|fifo_full);
    in_ack    = rst_n && (uni_ok || bc_ok);
  end
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    switch_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (in_ack && (bcast_eff || port_num == PORT_W'(i))),
      .pop_req(out_ack[i]),
      .din    (data_in),
      .valid  (ready_out[i]),
      .dout   (data_out[i*DATA_W +: DATA_W]),
      .full   (fifo_full[i])
    );
  end
endmodule

// File: doc/param_switch.md
PARAM_SWITCH -- requirements
Module: param_switch

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits.
REQ-002 Parameter NUM_PORTS, default 4, number of output ports; legal values are 2..16.
REQ-003 Parameter DEPTH, default 4, entries per output FIFO; legal values are powers of two, >=2.
REQ-004 Parameter BCAST_EN, default 1, enables broadcast writes; when 0, bcast_in is ignored.
REQ-005 Derived constant PORT_W = $clog2(NUM_PORTS).
REQ-006 Port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port ready_in, input, 1, input valid strobe.
REQ-009 Port data_in, input, DATA_W, input payload.
REQ-010 Port port_num, input, PORT_W, destination port index.
REQ-011 Port bcast_in, input, 1, broadcast request qualifying ready_in.
REQ-012 Port in_ack, output, 1, input accepted this cycle.
REQ-013 Port ready_out, output, NUM_PORTS, per-port data valid.
REQ-014 Port out_ack, input, NUM_PORTS, per-port consumer pop.
REQ-015 Port data_out, output, NUM_PORTS*DATA_W, packed per-port head data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-016 Port fifo_full, output, NUM_PORTS, per-port FIFO full flag.

Function
REQ-017 Each output port SHALL own one DEPTH-entry FIFO with registered count, read pointer and write pointer.
REQ-018 A unicast write SHALL occur when ready_in=1, bcast_in is effectively 0, and fifo_full[port_num]=0.
REQ-019 A broadcast write SHALL occur when ready_in=1, bcast_in=1, BCAST_EN=1, and every fifo_full bit is 0.
  - A broadcast write pushes data_in into all FIFOs in the same cycle.
REQ-020 in_ack SHALL be combinational from ready_in, bcast_in, port_num and registered fifo_full only, with no path from out_ack.
  - in_ack = 1 exactly when a write occurs.
REQ-021 Out-of-range port_num (>= NUM_PORTS) SHALL drive in_ack=0 and write nothing.
REQ-022 When ready_in=1 and in_ack=0, the source holds data_in, port_num and bcast_in stable; the block drops nothing.
REQ-023 ready_out[i] SHALL equal (count[i] != 0); an accepted word is visible on ready_out one cycle after in_ack.
REQ-024 data_out for port i SHALL present the FIFO head when ready_out[i]=1 and all-zeros when ready_out[i]=0.
REQ-025 A pop SHALL occur when out_ack[i]=1 and ready_out[i]=1; out_ack[i] while empty is ignored.
REQ-026 A simultaneous push and pop on the same port SHALL leave count unchanged and advance both pointers.
  - When full, the push is refused per REQ-020, so only the pop occurs.
REQ-027 Pointers SHALL wrap modulo DEPTH.
REQ-028 Count SHALL never exceed DEPTH or go below 0.
REQ-029 fifo_full[i] SHALL equal (count[i] == DEPTH).
REQ-030 Ordering per port SHALL be strict FIFO.
REQ-031 Words accepted to different ports are independent; no head-of-line blocking across ports beyond REQ-020.

Reset
REQ-032 rst_n=0 SHALL asynchronously clear all counts and pointers.
  - Resulting outputs: ready_out=0, data_out=0, fifo_full=0, and in_ack=0 (gated by rst_n).
REQ-033 Reset mid-operation SHALL discard all buffered words; the first cycle after rst_n rises behaves as post-reset idle.

Structure
REQ-034 A package switch_pkg SHALL hold the default parameter values and the PORT_W derivation function.
REQ-035 Per-port buffering SHALL be a sub-module switch_port_fifo, instantiated NUM_PORTS times by a generate loop.
REQ-036 FIFO storage SHALL NOT be reset; only control state is reset.

Verification
REQ-037 Unicast: write 0xA5 to port 2 at cycle t.
  - Expected: in_ack=1 at t; ready_out=4'b0100 and data_out port 2 = 0xA5 at t+1; all other ports read 0.
REQ-038 Fill port 1 with DEPTH=4 words 0x01..0x04, then request a fifth.
  - Expected: fifo_full[1]=1 and in_ack=0 on the fifth request.
  - After one out_ack[1], the fifth word is accepted, and pops return 0x01..0x05 in order.
REQ-039 Broadcast 0x3C with all ports empty.
  - Expected: all ready_out=1 next cycle, all data_out=0x3C.
  - Repeat the broadcast with port 3 full: in_ack=0 and no port count changes.
REQ-040 Simultaneous push and pop on port 0 holding 2 words: count stays 2 and the head advances; repeat when full and confirm the push is refused.
REQ-041 Assert rst_n=0 asynchronously with 3 words in port 0 and 2 in port 3.
  - Expected: ready_out=0 and data_out=0 immediately, without waiting for a clock edge; after release, out_ack has no effect until a new write.
REQ-042 Out-of-range port_num=5 with NUM_PORTS=5 (PORT_W=3).
  - Expected: in_ack=0 and no state change.
